// File: rtl/sqrt_arb_pkg.sv
// Shared types and default sizes for the square-root engine arbiter.
package sqrt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RES_W   = 16;
  localparam int TMO_CNT_W   = 8;

endpackage

// File: rtl/sqrt_engine_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid lane at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  always_comb begin
    // NOTE: blocking assignments with a default first keep this purely combinational (no latch).
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sqrt_engine_arbiter.sv
// Shares one iterative sqrt engine between NUM_REQ lanes with round-robin grant.
// Optional engine watchdog enabled by defining SQRT_ARB_TIMEOUT_EN.
module sqrt_engine_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int RES_W          = DEF_RES_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [RES_W-1:0]           resp_data,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic                       resp_err,
  output logic                       eng_start,
  output logic [DATA_W-1:0]          eng_in,
  input  logic [RES_W-1:0]           eng_out,
  input  logic                       eng_done,
  input  logic                       eng_avail
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("sqrt_engine_arbiter: NUM_REQ or TIMEOUT_CYCLES out of range");
  end

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic [DATA_W-1:0]   lane_data [NUM_REQ];
  logic                accept;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign lane_data[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The accept pulse is combinational so a lane sees it in the same cycle it is chosen.
  assign accept    = (state == IDLE) && eng_avail && !reset && (|req_valid);
  assign req_ready = accept ? grant : '0;

`ifdef SQRT_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    // NOTE: every register here is state, so only non-blocking assignments are used.
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      eng_start  <= 1'b0;
      eng_in     <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
      resp_err   <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            eng_in    <= lane_data[grant_idx];
            resp_id   <= grant_idx;
            eng_start <= 1'b1;
            state     <= BUSY;
`ifdef SQRT_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        BUSY: begin
          if (eng_done) begin
            resp_data  <= eng_out;
            eng_start  <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
`ifdef SQRT_ARB_TIMEOUT_EN
          end else if (tmo_cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Counter reaches TIMEOUT_CYCLES on this edge: give up on the engine.
            resp_data  <= '0;
            resp_err   <= 1'b1;
            eng_start  <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            tmo_cnt    <= tmo_cnt + TMO_CNT_W'(1);
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= (resp_id == IDX_W'(NUM_REQ - 1)) ? '0 : resp_id + IDX_W'(1);
            state      <= IDLE;
`ifdef SQRT_ARB_TIMEOUT_EN
            resp_err   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
